// File: rtl/vm_pkg.sv
// Shared definitions for the coin front end: coin codes, FSM encodings
// and small helpers for turning debounce qualifiers into coin codes.
package vm_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_20   = 2'b11;

  typedef enum logic [1:0] {
    SCH_IDLE  = 2'b00,
    SCH_ISSUE = 2'b01,
    SCH_GAP   = 2'b10
  } sched_state_t;

  typedef enum logic {
    DB_ARMED  = 1'b0,
    DB_LOCKED = 1'b1
  } db_state_t;

  // Qualifier bit 0/1/2 belongs to the Rs.5/Rs.10/Rs.20 sensor.
  function automatic logic [1:0] qual_code(input logic [2:0] q);
    logic [1:0] code;
    code = COIN_NONE;
    case (q)
      3'b001:  code = COIN_5;
      3'b010:  code = COIN_10;
      3'b100:  code = COIN_20;
      default: code = COIN_NONE;
    endcase
    return code;
  endfunction

  function automatic logic multi_qual(input logic [2:0] q);
    return (q & (q - 3'd1)) != 3'b000;
  endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Sensor inputs and coin/status outputs of the coin acceptor; the DUT
// takes the slave side, the driver of the sensors takes the master side.
interface coin_acceptor_if #(
  parameter int DEPTH = 4
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic          sns_5;
  logic          sns_10;
  logic          sns_20;
  logic          accept_en;
  logic [1:0]    coin;
  logic          coin_reject;
  logic          fifo_full;
  logic [PW-1:0] pending;

  modport master (
    output sns_5,
    output sns_10,
    output sns_20,
    output accept_en,
    input  coin,
    input  coin_reject,
    input  fifo_full,
    input  pending
  );

  modport slave (
    input  sns_5,
    input  sns_10,
    input  sns_20,
    input  accept_en,
    output coin,
    output coin_reject,
    output fifo_full,
    output pending
  );

endinterface

// File: rtl/coin_debounce.sv
// One sensor lane: two-flop synchroniser, then an ARMED/LOCKED debouncer
// that emits one single-cycle qual per sufficiently long high episode.
module coin_debounce
  import vm_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sns,
  output logic qual
);

  localparam logic [7:0] LAST = 8'(DEBOUNCE - 1);

  logic      sync1;
  logic      sync2;
  db_state_t state;
  db_state_t state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic      qual_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= DB_ARMED;
      cnt   <= 8'd0;
      qual  <= 1'b0;
    end else begin
      sync1 <= sns;
      sync2 <= sync1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      qual  <= qual_nxt;
    end
  end

  // The counter tracks the current run length; the edge that would make it
  // reach DEBOUNCE flips the state instead of storing the final count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    qual_nxt  = 1'b0;
    case (state)
      DB_ARMED: begin
        if (sync2) begin
          if (cnt == LAST) begin
            qual_nxt  = 1'b1;
            state_nxt = DB_LOCKED;
            cnt_nxt   = 8'd0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end else begin
          cnt_nxt = 8'd0;
        end
      end
      DB_LOCKED: begin
        if (!sync2) begin
          if (cnt == LAST) begin
            state_nxt = DB_ARMED;
            cnt_nxt   = 8'd0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end else begin
          cnt_nxt = 8'd0;
        end
      end
      default: begin
        state_nxt = DB_ARMED;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin front end: three debounced sensor lanes, accept/reject decision, a
// small coin FIFO and a scheduler replaying one coin per GAP+2 cycles.
module coin_acceptor
  import vm_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int DEPTH    = 4,
  parameter int GAP      = 2
) (
  input  logic            clk,
  input  logic            rst,
  coin_acceptor_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [7:0] GAP_INIT = 8'(GAP);

  logic [2:0]   qual;
  logic [1:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_nxt;
  logic [PW-1:0] rd_nxt;
  logic [PW-1:0] occ_nxt;
  logic          full_now;
  logic          empty_now;
  logic          push;
  logic          pop;
  logic          reject_nxt;
  logic [1:0]    coin_q;
  logic [1:0]    coin_nxt;
  logic          coin_reject_q;
  logic          fifo_full_q;
  logic [PW-1:0] pending_q;
  sched_state_t  state;
  sched_state_t  state_nxt;
  logic [7:0]    gap_cnt;
  logic [7:0]    gap_nxt;

  coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_5 (
    .clk  (clk),
    .rst  (rst),
    .sns  (bus.sns_5),
    .qual (qual[0])
  );

  coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_10 (
    .clk  (clk),
    .rst  (rst),
    .sns  (bus.sns_10),
    .qual (qual[1])
  );

  coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_20 (
    .clk  (clk),
    .rst  (rst),
    .sns  (bus.sns_20),
    .qual (qual[2])
  );

  assign full_now  = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty_now = (wr_ptr == rd_ptr);

  // Fullness is judged before this edge's pop, so a simultaneous pop never
  // rescues a coin that arrives while the FIFO is full.
  always_comb begin
    push       = 1'b0;
    reject_nxt = 1'b0;
    if (qual != 3'b000) begin
      if (multi_qual(qual) || !bus.accept_en || full_now) begin
        reject_nxt = 1'b1;
      end else begin
        push = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    pop       = 1'b0;
    coin_nxt  = COIN_NONE;
    case (state)
      SCH_IDLE: begin
        if (!empty_now) begin
          pop       = 1'b1;
          coin_nxt  = mem[rd_ptr[AW-1:0]];
          state_nxt = SCH_ISSUE;
        end
      end
      SCH_ISSUE: begin
        state_nxt = SCH_GAP;
        gap_nxt   = GAP_INIT;
      end
      SCH_GAP: begin
        if (gap_cnt <= 8'd1) begin
          state_nxt = SCH_IDLE;
        end else begin
          gap_nxt = gap_cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = SCH_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_nxt  = wr_ptr + PW'(push);
    rd_nxt  = rd_ptr + PW'(pop);
    occ_nxt = wr_nxt - rd_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      state         <= SCH_IDLE;
      gap_cnt       <= 8'd0;
      coin_q        <= COIN_NONE;
      coin_reject_q <= 1'b0;
      fifo_full_q   <= 1'b0;
      pending_q     <= '0;
    end else begin
      wr_ptr        <= wr_nxt;
      rd_ptr        <= rd_nxt;
      state         <= state_nxt;
      gap_cnt       <= gap_nxt;
      coin_q        <= coin_nxt;
      coin_reject_q <= reject_nxt;
      fifo_full_q   <= (wr_nxt[AW] != rd_nxt[AW]) &&
                       (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
      pending_q     <= occ_nxt;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= qual_code(qual);
    end
  end

  assign bus.coin        = coin_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.fifo_full   = fifo_full_q;
  assign bus.pending     = pending_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: an event-level model of sensor
// episodes, coin queue and issue slots, plus directed scenarios.
module tb_coin_acceptor;
  import vm_pkg::*;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  coin_acceptor_if #(.DEPTH(DEPTH)) bus ();

  coin_acceptor #(.DEBOUNCE(DEB), .DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: sampled-input delay line, run lengths, coin queue, slot timing.
  int         edge_n = 0;
  bit         model_ok = 1'b0;
  bit         d1 [3];
  bit         d2 [3];
  int         hrun [3];
  int         lrun [3];
  bit         armed [3];
  bit         m_qual [3];
  logic [1:0] q_fifo [$];
  int         next_pop = 0;
  int         exp_coin = 0;
  int         exp_rej  = 0;
  int         exp_full = 0;
  int         exp_pend = 0;

  int mon_coins = 0;
  int mon_rej   = 0;
  int mon_last  = 0;
  bit mon_full  = 1'b0;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model_p
    bit raw [3];
    bit lvl;
    bit full_pre;
    int nq;
    int qi;
    raw[0] = bus.sns_5;
    raw[1] = bus.sns_10;
    raw[2] = bus.sns_20;
    edge_n++;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        d1[i] = 0; d2[i] = 0; hrun[i] = 0; lrun[i] = 0;
        armed[i] = 1; m_qual[i] = 0;
      end
      q_fifo.delete();
      next_pop = edge_n + 1;
      exp_coin = 0; exp_rej = 0; exp_full = 0; exp_pend = 0;
      model_ok = 1'b1;
    end else begin
      nq = 0;
      qi = 0;
      for (int i = 0; i < 3; i++) begin
        if (m_qual[i]) begin
          nq++;
          qi = i;
        end
      end
      full_pre = (q_fifo.size() == DEPTH);
      exp_coin = 0;
      if (q_fifo.size() > 0 && edge_n >= next_pop) begin
        exp_coin = int'(q_fifo.pop_front());
        next_pop = edge_n + GAP + 2;
      end
      exp_rej = ((nq > 1) || (nq == 1 && (!bus.accept_en || full_pre))) ? 1 : 0;
      if (nq == 1 && exp_rej == 0) q_fifo.push_back(2'(qi + 1));
      exp_pend = q_fifo.size();
      exp_full = (q_fifo.size() == DEPTH) ? 1 : 0;
      for (int i = 0; i < 3; i++) begin
        lvl = d2[i];
        d2[i] = d1[i];
        d1[i] = raw[i];
        m_qual[i] = 0;
        if (armed[i]) begin
          if (lvl) begin
            hrun[i]++;
            if (hrun[i] == DEB) begin
              m_qual[i] = 1; armed[i] = 0; hrun[i] = 0; lrun[i] = 0;
            end
          end else begin
            hrun[i] = 0;
          end
        end else begin
          if (!lvl) begin
            lrun[i]++;
            if (lrun[i] == DEB) begin
              armed[i] = 1; lrun[i] = 0; hrun[i] = 0;
            end
          end else begin
            lrun[i] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      checkOutput("coin", int'(bus.coin), exp_coin);
      checkOutput("coin_reject", int'(bus.coin_reject), exp_rej);
      checkOutput("fifo_full", int'(bus.fifo_full), exp_full);
      checkOutput("pending", int'(bus.pending), exp_pend);
      if (bus.coin != COIN_NONE) begin
        mon_coins++;
        mon_last = int'(bus.coin);
      end
      if (bus.coin_reject) mon_rej++;
      if (bus.fifo_full) mon_full = 1'b1;
    end
  end

  task automatic clearMon();
    mon_coins = 0;
    mon_rej   = 0;
    mon_last  = 0;
    mon_full  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit s5, input bit s10, input bit s20, input bit en);
    @(negedge clk);
    bus.sns_5     = s5;
    bus.sns_10    = s10;
    bus.sns_20    = s20;
    bus.accept_en = en;
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    bus.sns_5 = 0; bus.sns_10 = 0; bus.sns_20 = 0; bus.accept_en = 1;
    idle(3);
    checkOutput("reset_coin", int'(bus.coin), 0);
    checkOutput("reset_pending", int'(bus.pending), 0);
    checkOutput("reset_full", int'(bus.fifo_full), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    // Single Rs.10 held 10 cycles: coin at 8 negedges after the drive.
    clearMon();
    applyStimulus(0, 1, 0, 1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 7) checkOutput("t1_pending_up", int'(bus.pending), 1);
      if (k == 8) begin
        checkOutput("t1_coin", int'(bus.coin), 2);
        checkOutput("t1_pending_down", int'(bus.pending), 0);
      end
      if (k == 9) checkOutput("t1_coin_width", int'(bus.coin), 0);
      if (k == 10) bus.sns_10 = 0;
    end
    idle(10);
    checkOutput("t1_coin_count", mon_coins, 1);
    checkOutput("t1_reject_count", mon_rej, 0);

    // Short glitch on Rs.5 is ignored.
    clearMon();
    applyStimulus(1, 0, 0, 1);
    idle(2);
    applyStimulus(0, 0, 0, 1);
    idle(14);
    checkOutput("t2_coin_count", mon_coins, 0);
    checkOutput("t2_reject_count", mon_rej, 0);

    // Staggered 4-high/4-low waves on all sensors overrun the FIFO.
    clearMon();
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      bus.sns_5  = (c < 64) && ((c % 8) < 4);
      bus.sns_10 = (c >= 1) && (c < 65) && (((c - 1) % 8) < 4);
      bus.sns_20 = (c >= 2) && (c < 66) && (((c - 2) % 8) < 4);
    end
    idle(30);
    checkOutput("t3_saw_full", int'(mon_full), 1);
    checkOutput("t3_saw_reject", (mon_rej > 0) ? 1 : 0, 1);
    checkOutput("t3_drained", int'(bus.pending), 0);

    // Two sensors qualifying together are returned.
    clearMon();
    applyStimulus(1, 1, 0, 1);
    idle(5);
    applyStimulus(0, 0, 0, 1);
    idle(14);
    checkOutput("t4_reject_count", mon_rej, 1);
    checkOutput("t4_coin_count", mon_coins, 0);
    checkOutput("t4_pending", int'(bus.pending), 0);

    // Queue 01,10,11 then reset during the first gap.
    clearMon();
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 1, 0, 1);
    applyStimulus(1, 1, 1, 1);
    applyStimulus(1, 1, 1, 1);
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (bus.coin != COIN_NONE) found = 1'b1;
    end
    checkOutput("t5_first_coin_seen", int'(found), 1);
    checkOutput("t5_first_coin", int'(bus.coin), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t5_rst_coin", int'(bus.coin), 0);
    checkOutput("t5_rst_pending", int'(bus.pending), 0);
    checkOutput("t5_rst_full", int'(bus.fifo_full), 0);
    clearMon();
    idle(20);
    checkOutput("t5_no_coins_after", mon_coins, 0);

    // Disabled acceptance rejects; re-enabled acceptance issues Rs.20.
    clearMon();
    applyStimulus(0, 0, 1, 0);
    idle(4);
    applyStimulus(0, 0, 0, 0);
    idle(10);
    checkOutput("t6_disabled_reject", mon_rej, 1);
    checkOutput("t6_disabled_coins", mon_coins, 0);
    clearMon();
    applyStimulus(0, 0, 1, 1);
    idle(4);
    applyStimulus(0, 0, 0, 1);
    idle(12);
    checkOutput("t6_enabled_coins", mon_coins, 1);
    checkOutput("t6_enabled_code", mon_last, 3);
    checkOutput("t6_enabled_reject", mon_rej, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
